// File: rtl/isolde_exec_dispatch.sv
// ---------------------------------------------------------------------------
// isolde_exec_dispatch
//
// Buffers decoded ISOLDE custom instructions between the decoder and the
// execute unit. Complete, legal instructions go into a small circular FIFO.
// The head entry is presented to the execute unit through a valid/ready
// handshake. Illegal instructions are rejected with a one-cycle pulse.
// Saturating counters record issued and illegal instructions.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_i               synchronous clear of the buffer from execute control
//   dec_*_i               decoder request: enable/illegal/ready, opcode,
//                         func3, funct2, raw instr, immediates + per-slot valid
//   stall_o               back-pressure to the decoder (full or flushing)
//   issue_valid_o/ready_i handshake toward the execute unit
//   issue_*_o             head entry contents (all-zero when empty)
//   illegal_o             one-cycle pulse per rejected illegal instruction
//   issued_cnt_o          saturating count of issued (popped) instructions
//   illegal_cnt_o         saturating count of rejected instructions
// ---------------------------------------------------------------------------
module isolde_exec_dispatch #(
    parameter int IMM32_OPS = 4,
    parameter int DEPTH     = 2,
    parameter int OPC_W     = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           dec_enable_i,
    input  logic                           dec_illegal_i,
    input  logic                           dec_ready_i,
    input  logic [OPC_W-1:0]               dec_opcode_i,
    input  logic [2:0]                     dec_func3_i,
    input  logic [1:0]                     dec_funct2_i,
    input  logic [31:0]                    dec_instr_i,
    input  logic [IMM32_OPS*32-1:0]        dec_imm32_i,
    input  logic [IMM32_OPS-1:0]           dec_imm32_valid_i,
    output logic                           stall_o,
    output logic                           issue_valid_o,
    input  logic                           issue_ready_i,
    output logic [OPC_W-1:0]               issue_opcode_o,
    output logic [2:0]                     issue_func3_o,
    output logic [1:0]                     issue_funct2_o,
    output logic [31:0]                    issue_instr_o,
    output logic [IMM32_OPS*32-1:0]        issue_imm32_o,
    output logic [$clog2(IMM32_OPS+1)-1:0] issue_nimm_o,
    output logic                           illegal_o,
    output logic [15:0]                    issued_cnt_o,
    output logic [15:0]                    illegal_cnt_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int NIMM_W = $clog2(IMM32_OPS + 1);
    localparam int IMM_W  = IMM32_OPS * 32;

    // Number of immediate slots flagged valid.
    function automatic logic [NIMM_W-1:0] f_popcount(input logic [IMM32_OPS-1:0] v);
        logic [NIMM_W-1:0] n;
        n = '0;
        for (int k = 0; k < IMM32_OPS; k++) begin
            n = n + NIMM_W'(v[k]);
        end
        return n;
    endfunction

    // Saturating 16-bit increment.
    function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Buffer storage. It holds data only and has no reset: occupancy gates
    // everything that reaches the outputs.
    logic [OPC_W-1:0]  r_opc   [DEPTH];
    logic [2:0]        r_f3    [DEPTH];
    logic [1:0]        r_f2    [DEPTH];
    logic [31:0]       r_instr [DEPTH];
    logic [IMM_W-1:0]  r_imm   [DEPTH];
    logic [NIMM_W-1:0] r_nimm  [DEPTH];

    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_illegal;
    logic [15:0]       r_issued_cnt;
    logic [15:0]       r_illegal_cnt;

    logic              w_full;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_illegal;
    logic [IMM_W-1:0]  w_imm_masked;

    // Slots without a valid bit are stored as zero.
    for (genvar k = 0; k < IMM32_OPS; k++) begin : g_imm_mask
        assign w_imm_masked[32*k +: 32] = dec_imm32_valid_i[k] ? dec_imm32_i[32*k +: 32] : 32'h0;
    end

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_valid   = (r_count != '0);
    assign stall_o   = w_full | flush_i;
    // A full buffer raises stall_o, so push is never attempted on full.
    assign w_push    = dec_enable_i & dec_ready_i & ~dec_illegal_i & ~stall_o & ~flush_i;
    assign w_pop     = w_valid & issue_ready_i & ~flush_i;
    // Illegal rejection ignores dec_ready_i and stall_o.
    assign w_illegal = dec_enable_i & dec_illegal_i & ~flush_i;

    assign issue_valid_o  = w_valid;
    assign issue_opcode_o = w_valid ? r_opc[r_rptr]   : '0;
    assign issue_func3_o  = w_valid ? r_f3[r_rptr]    : '0;
    assign issue_funct2_o = w_valid ? r_f2[r_rptr]    : '0;
    assign issue_instr_o  = w_valid ? r_instr[r_rptr] : '0;
    assign issue_imm32_o  = w_valid ? r_imm[r_rptr]   : '0;
    assign issue_nimm_o   = w_valid ? r_nimm[r_rptr]  : '0;
    assign illegal_o      = r_illegal;
    assign issued_cnt_o   = r_issued_cnt;
    assign illegal_cnt_o  = r_illegal_cnt;

    // Entry write.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_opc[r_wptr]   <= dec_opcode_i;
            r_f3[r_wptr]    <= dec_func3_i;
            r_f2[r_wptr]    <= dec_funct2_i;
            r_instr[r_wptr] <= dec_instr_i;
            r_imm[r_wptr]   <= w_imm_masked;
            r_nimm[r_wptr]  <= f_popcount(dec_imm32_valid_i);
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap naturally at their width.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Illegal pulse and event counters. flush_i already masks push, pop
    // and the illegal pulse, and the counters keep their values across it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_illegal     <= 1'b0;
            r_issued_cnt  <= '0;
            r_illegal_cnt <= '0;
        end else begin
            r_illegal <= w_illegal;
            if (w_pop)     r_issued_cnt  <= f_sat_inc(r_issued_cnt);
            if (w_illegal) r_illegal_cnt <= f_sat_inc(r_illegal_cnt);
        end
    end

endmodule

// File: tb/tb_isolde_exec_dispatch.sv
// ---------------------------------------------------------------------------
// Testbench for isolde_exec_dispatch. The reference model is a queue of
// entries plus integer counters, advanced once per clock from the current
// inputs.
// ---------------------------------------------------------------------------
module tb_isolde_exec_dispatch;

    localparam int IMM32_OPS = 4;
    localparam int DEPTH     = 2;
    localparam int OPC_W     = 8;
    localparam int IMM_W     = IMM32_OPS * 32;
    localparam int NIMM_W    = $clog2(IMM32_OPS + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               en, ill, rdy;
    logic [OPC_W-1:0]   opc;
    logic [2:0]         f3;
    logic [1:0]         f2;
    logic [31:0]        instr;
    logic [IMM_W-1:0]   imm;
    logic [IMM32_OPS-1:0] immv;
    logic               stall;
    logic               iv, ir;
    logic [OPC_W-1:0]   i_opc;
    logic [2:0]         i_f3;
    logic [1:0]         i_f2;
    logic [31:0]        i_instr;
    logic [IMM_W-1:0]   i_imm;
    logic [NIMM_W-1:0]  i_nimm;
    logic               illegal;
    logic [15:0]        issued_cnt, illegal_cnt;

    always #5 clk = ~clk;

    isolde_exec_dispatch #(.IMM32_OPS(IMM32_OPS), .DEPTH(DEPTH), .OPC_W(OPC_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .dec_enable_i(en), .dec_illegal_i(ill), .dec_ready_i(rdy),
        .dec_opcode_i(opc), .dec_func3_i(f3), .dec_funct2_i(f2),
        .dec_instr_i(instr), .dec_imm32_i(imm), .dec_imm32_valid_i(immv),
        .stall_o(stall), .issue_valid_o(iv), .issue_ready_i(ir),
        .issue_opcode_o(i_opc), .issue_func3_o(i_f3), .issue_funct2_o(i_f2),
        .issue_instr_o(i_instr), .issue_imm32_o(i_imm), .issue_nimm_o(i_nimm),
        .illegal_o(illegal), .issued_cnt_o(issued_cnt), .illegal_cnt_o(illegal_cnt)
    );

    typedef struct {
        logic [OPC_W-1:0] opc;
        logic [2:0]       f3;
        logic [1:0]       f2;
        logic [31:0]      instr;
        logic [IMM_W-1:0] imm;
        int               nimm;
    } ent_t;

    ent_t q[$];
    int   m_issued, m_illcnt;
    bit   m_pulse;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic model_reset();
        q.delete();
        m_issued = 0;
        m_illcnt = 0;
        m_pulse  = 0;
    endtask

    // Advance the model from the current inputs, then clock the DUT.
    task automatic tick();
        ent_t e;
        bit   full, do_push, do_pop, do_ill;
        full    = (q.size() == DEPTH);
        do_push = en && rdy && !ill && !full && !flush;
        do_pop  = (q.size() != 0) && ir && !flush;
        do_ill  = en && ill && !flush;
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                if (m_issued < 65535) m_issued++;
            end
            if (do_push) begin
                e.opc = opc; e.f3 = f3; e.f2 = f2; e.instr = instr;
                e.nimm = $countones(immv);
                for (int k = 0; k < IMM32_OPS; k++)
                    e.imm[32*k +: 32] = immv[k] ? imm[32*k +: 32] : 32'h0;
                q.push_back(e);
            end
        end
        m_pulse = do_ill;
        if (do_ill && m_illcnt < 65535) m_illcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; ill = 0; rdy = 0; flush = 0; ir = 0;
        opc = '0; f3 = '0; f2 = '0; instr = '0; imm = '0; immv = '0;
    endtask

    task automatic drive_push(input logic [OPC_W-1:0] o, input logic [31:0] ins,
                              input logic [IMM32_OPS-1:0] v);
        en = 1; ill = 0; rdy = 1;
        opc = o; instr = ins; immv = v;
        f3 = ins[14:12]; f2 = 2'($urandom_range(0, 3));
        for (int k = 0; k < IMM32_OPS; k++) imm[32*k +: 32] = $urandom;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #12;
        n_checks++; if (iv !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", iv); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        n_checks++; if (i_instr !== 32'h0 || i_imm !== '0 || i_nimm !== '0) begin
            n_fail++; $display("FAIL reset_data got instr=%h nimm=%0d exp=0", i_instr, i_nimm); end
        n_checks++; if (issued_cnt !== 16'h0 || illegal_cnt !== 16'h0 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt got issued=%0d illcnt=%0d ill=%0b exp=0", issued_cnt, illegal_cnt, illegal); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_push();
        logic [IMM_W-1:0] exp_imm;
        en = 1; ill = 0; rdy = 1; ir = 0;
        opc = 8'h05; instr = 32'h0000_500B; f3 = 3'd5; f2 = 2'd0; immv = 4'b0101;
        imm = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        tick();
        idle();
        #1;
        exp_imm = {32'h0, 32'hCCCC_0003, 32'h0, 32'hAAAA_0001};
        n_checks++; if (iv !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0b exp=1", iv); end
        n_checks++; if (i_imm !== exp_imm) begin n_fail++; $display("FAIL single_imm got=%h exp=%h", i_imm, exp_imm); end
        n_checks++; if (i_nimm !== 3'd2) begin n_fail++; $display("FAIL single_nimm got=%0d exp=2", i_nimm); end
        n_checks++; if (i_opc !== 8'h05 || i_instr !== 32'h0000_500B || i_f3 !== 3'd5) begin
            n_fail++; $display("FAIL single_fields got opc=%h instr=%h f3=%0d exp opc=05 instr=0000500b f3=5", i_opc, i_instr, i_f3); end
        ir = 1;
        tick();
        ir = 0;
    endtask

    task automatic test_back_to_back();
        int base;
        base = issued_cnt;
        ir = 0;
        drive_push(8'h11, 32'h0000_0100, 4'b0001); tick();
        drive_push(8'h12, 32'h0000_0200, 4'b0011); tick();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_full got=%0b exp=1", stall); end
        drive_push(8'h13, 32'h0000_0300, 4'b0111); tick();
        n_checks++; if (i_instr !== 32'h100) begin n_fail++; $display("FAIL b2b_held_head got=%h exp=100", i_instr); end
        ir = 1;
        tick();
        n_checks++; if (stall !== 1'b0 || i_instr !== 32'h200) begin
            n_fail++; $display("FAIL b2b_first_pop got stall=%0b instr=%h exp stall=0 instr=200", stall, i_instr); end
        tick();
        en = 0;
        #1;
        n_checks++; if (i_instr !== 32'h300 || i_nimm !== 3'd3) begin
            n_fail++; $display("FAIL b2b_third got instr=%h nimm=%0d exp instr=300 nimm=3", i_instr, i_nimm); end
        tick();
        ir = 0;
        n_checks++; if (issued_cnt !== 16'(base + 3) || iv !== 1'b0) begin
            n_fail++; $display("FAIL b2b_issued got=%0d valid=%0b exp=%0d valid=0", issued_cnt, iv, base + 3); end
    endtask

    task automatic test_push_pop_same();
        ir = 0;
        drive_push(8'h21, 32'h0000_0A00, 4'b1000); tick();
        drive_push(8'h22, 32'h0000_0B00, 4'b1100);
        ir = 1;
        tick();
        idle();
        #1;
        n_checks++; if (iv !== 1'b1 || i_instr !== 32'hB00 || stall !== 1'b0) begin
            n_fail++; $display("FAIL pushpop got valid=%0b instr=%h stall=%0b exp valid=1 instr=b00 stall=0", iv, i_instr, stall); end
        ir = 1;
        tick();
        n_checks++; if (iv !== 1'b0) begin n_fail++; $display("FAIL pushpop_drain got=%0b exp=0", iv); end
        ir = 0;
    endtask

    task automatic test_illegal();
        int base;
        base = illegal_cnt;
        en = 1; ill = 1; rdy = 1; instr = 32'hDEAD_000B; immv = 4'b1111;
        tick();
        idle();
        #1;
        n_checks++; if (illegal !== 1'b1 || illegal_cnt !== 16'(base + 1)) begin
            n_fail++; $display("FAIL illegal_pulse got ill=%0b cnt=%0d exp ill=1 cnt=%0d", illegal, illegal_cnt, base + 1); end
        n_checks++; if (iv !== 1'b0) begin n_fail++; $display("FAIL illegal_nopush got=%0b exp=0", iv); end
        tick();
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_width got=%0b exp=0", illegal); end
    endtask

    task automatic test_flush();
        int base;
        base = issued_cnt;
        ir = 0;
        drive_push(8'h31, 32'h0000_0C00, 4'b0001); tick();
        drive_push(8'h32, 32'h0000_0D00, 4'b0001); tick();
        drive_push(8'h33, 32'h0000_0E00, 4'b0001);
        flush = 1;
        ir = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall got=%0b exp=1", stall); end
        tick();
        idle();
        #1;
        n_checks++; if (iv !== 1'b0 || stall !== 1'b0 || issued_cnt !== 16'(base)) begin
            n_fail++; $display("FAIL flush_clear got valid=%0b stall=%0b issued=%0d exp valid=0 stall=0 issued=%0d", iv, stall, issued_cnt, base); end
    endtask

    task automatic test_async_reset_wrap();
        ir = 0;
        drive_push(8'h41, 32'h0000_0F00, 4'b0001); tick();
        drive_push(8'h42, 32'h0000_0F01, 4'b0001); tick();
        idle();
        #1;
        rst_n = 0;
        #1;
        n_checks++; if (iv !== 1'b0 || stall !== 1'b0 || issued_cnt !== 16'h0 || i_instr !== 32'h0) begin
            n_fail++; $display("FAIL async_reset got valid=%0b stall=%0b issued=%0d instr=%h exp 0", iv, stall, issued_cnt, i_instr); end
        model_reset();
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        drive_push(8'h43, 32'h0000_0F02, 4'b0010); tick();
        idle();
        #1;
        n_checks++; if (iv !== 1'b1 || i_instr !== 32'hF02 || i_nimm !== 3'd1) begin
            n_fail++; $display("FAIL after_reset got valid=%0b instr=%h nimm=%0d exp valid=1 instr=f02 nimm=1", iv, i_instr, i_nimm); end
        ir = 1; tick();
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            drive_push(8'h50, 32'h0000_1000 + i, 4'b0001);
            ir = 1;
            #1;
            if (i > 0) begin
                n_checks++;
                if (i_instr !== 32'h0000_1000 + i - 1 || stall !== 1'b0) begin
                    n_fail++; $display("FAIL wrap_order got instr=%h stall=%0b exp instr=%h stall=0", i_instr, stall, 32'h1000 + i - 1); end
            end
            tick();
        end
        idle(); ir = 1; tick(); ir = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en    = ($urandom_range(0, 9) < 7);
            ill   = ($urandom_range(0, 9) < 2);
            rdy   = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            ir    = $urandom_range(0, 1);
            opc   = OPC_W'($urandom);
            f3    = 3'($urandom);
            f2    = 2'($urandom);
            instr = $urandom;
            immv  = IMM32_OPS'($urandom);
            for (int k = 0; k < IMM32_OPS; k++) imm[32*k +: 32] = $urandom;
            #1;
            n_checks++;
            if (stall !== ((q.size() == DEPTH) || flush) || iv !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_ctrl c=%0d got stall=%0b valid=%0b exp occupancy=%0d flush=%0b", c, stall, iv, q.size(), flush); end
            n_checks++;
            if (q.size() == 0) begin
                if (i_opc !== '0 || i_instr !== '0 || i_imm !== '0 || i_nimm !== '0 || i_f3 !== '0 || i_f2 !== '0) begin
                    n_fail++; $display("FAIL rnd_empty_data c=%0d got instr=%h exp 0", c, i_instr); end
            end else if (i_opc !== q[0].opc || i_f3 !== q[0].f3 || i_f2 !== q[0].f2 || i_instr !== q[0].instr ||
                         i_imm !== q[0].imm || i_nimm !== NIMM_W'(q[0].nimm)) begin
                n_fail++; $display("FAIL rnd_head c=%0d got instr=%h nimm=%0d exp instr=%h nimm=%0d", c, i_instr, i_nimm, q[0].instr, q[0].nimm);
            end
            n_checks++;
            if (illegal !== m_pulse || issued_cnt !== 16'(m_issued) || illegal_cnt !== 16'(m_illcnt)) begin
                n_fail++; $display("FAIL rnd_cnt c=%0d got ill=%0b issued=%0d illcnt=%0d exp ill=%0b issued=%0d illcnt=%0d",
                                   c, illegal, issued_cnt, illegal_cnt, m_pulse, m_issued, m_illcnt); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_push_pop_same();
        test_illegal();
        test_flush();
        test_async_reset_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/isolde_exec_dispatch.md
ISOLDE_EXEC_DISPATCH -- requirements
Module: isolde_exec_dispatch

Interface
REQ-001 SHALL have parameter IMM32_OPS, default 4, number of 32-bit immediate operand slots per custom instruction.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter OPC_W, default 8, width of the decoded ISOLDE opcode.
REQ-004 SHALL have port clk_i  input  1  clock; one clock domain, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  synchronous buffer clear from execute control.
REQ-007 SHALL have port dec_enable_i  input  1  decoder presents a custom instruction.
REQ-008 SHALL have port dec_illegal_i  input  1  presented instruction is unsupported.
REQ-009 SHALL have port dec_ready_i  input  1  all required immediates collected; instruction complete.
REQ-010 SHALL have port dec_opcode_i  input  OPC_W  decoded opcode.
REQ-011 SHALL have port dec_func3_i  input  3  instr[14:12].
REQ-012 SHALL have port dec_funct2_i  input  2  funct2 field.
REQ-013 SHALL have port dec_instr_i  input  32  raw instruction word.
REQ-014 SHALL have port dec_imm32_i  input  IMM32_OPS*32  immediate operands, slot k at bits [32k+31:32k].
REQ-015 SHALL have port dec_imm32_valid_i  input  IMM32_OPS  per-slot validity.
REQ-016 SHALL have port stall_o  output  1  stall the decoder.
REQ-017 SHALL have ports issue_valid_o out 1, issue_ready_i in 1: issue handshake toward execute unit.
REQ-018 SHALL have ports issue_opcode_o OPC_W, issue_func3_o 3, issue_funct2_o 2, issue_instr_o 32, issue_imm32_o IMM32_OPS*32, issue_nimm_o $clog2(IMM32_OPS+1): head entry contents, all outputs.
REQ-019 SHALL have port illegal_o  output  1  one-cycle pulse per rejected illegal instruction.
REQ-020 SHALL have ports issued_cnt_o out 16, illegal_cnt_o out 16: saturating event counters.

Function
REQ-021 Accept (push) SHALL occur in a cycle iff dec_enable_i & dec_ready_i & !dec_illegal_i & !stall_o & !flush_i.
REQ-022 Pushed entry SHALL store opcode, func3, funct2, instr, and each imm slot k as dec_imm32_i slot k when valid bit k set, else 32'h0.
REQ-023 Pushed entry SHALL store nimm = popcount(dec_imm32_valid_i).
REQ-024 Buffer SHALL be a circular FIFO with read/write pointers wrapping modulo DEPTH and an occupancy count 0..DEPTH.
REQ-025 stall_o SHALL be combinational: (count == DEPTH) | flush_i.
REQ-026 Pop SHALL occur iff issue_valid_o & issue_ready_i & !flush_i; issue_valid_o = (count != 0).
REQ-027 issue_* data outputs SHALL reflect the head entry combinationally; when empty they SHALL be all-zero.
REQ-028 Push-to-issue latency SHALL be one cycle: entry pushed at edge N is visible with issue_valid_o high after edge N.
REQ-029 Simultaneous push and pop SHALL leave count unchanged; when full no push occurs (stall_o high), so only the pop applies.
REQ-030 Illegal: dec_enable_i & dec_illegal_i & !flush_i SHALL register illegal_o=1 for exactly the next cycle, increment illegal_cnt_o, never push, regardless of dec_ready_i or stall_o.
REQ-031 issued_cnt_o SHALL increment on every pop; both counters SHALL saturate at 16'hFFFF.
REQ-032 flush_i SHALL, at the next edge, zero count and both pointers, suppress push, pop and illegal pulse that cycle; counters retain value.
REQ-033 dec_enable_i low SHALL ignore all other dec_* inputs.

Reset
REQ-034 On rst_ni low, immediately and asynchronously: count=0, pointers=0, illegal_o=0, issue_valid_o=0, issue data outputs zero, stall_o=0 (with flush_i low), issued_cnt_o=0, illegal_cnt_o=0.
REQ-035 Reset asserted mid-operation SHALL discard all buffered entries; first push after release behaves as from empty.

Verification
REQ-036 Push opcode 8'h05, instr 32'h0000_500B, valid 4'b0101, imm slots {A,B,C,D}, issue_ready_i=0 -> next cycle issue_valid_o=1, imm = {0,C? no: slot0=A,slot1=0,slot2=C,slot3=0}, issue_nimm_o=2.
REQ-037 Three back-to-back pushes, issue_ready_i=0, DEPTH=2 -> stall_o=1 after second push, third held off; raise issue_ready_i -> entries issued in order, stall_o drops after first pop, third accepted, issued_cnt_o=3.
REQ-038 Count=1 with issue_ready_i=1 and a push same cycle -> count stays 1, new entry at head next cycle, no stall.
REQ-039 dec_enable_i=1, dec_illegal_i=1, dec_ready_i=1 -> illegal_o pulse exactly one cycle, illegal_cnt_o=1, issue_valid_o stays 0.
REQ-040 Buffer full, assert flush_i one cycle with push attempted -> stall_o=1 that cycle, count=0 next, issue_valid_o=0, issued_cnt_o unchanged.
REQ-041 Assert rst_ni low between clock edges with count=2 -> issue_valid_o and stall_o fall without a clock edge; after release, first push issues normally; pointer wrap exercised by >= 2*DEPTH push/pop pairs with data order preserved.
